// File: rtl/kmp_detector_ctrl.sv
// Runtime-programmable serial sequence detector: loads a pattern, builds its KMP
// failure table one step per cycle, then scans a valid/ready bit stream for matches.
module kmp_detector_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_bit,
    input  logic             cfg_last,
    input  logic             overlap,
    input  logic             start,
    input  logic             stop,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             data_in,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] pat_len,
    output logic [1:0]       state_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_READY = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [MAX_LEN-1:0]            pat_q, pat_d;
    logic [MAX_LEN-1:0][LEN_W-1:0] fail_q, fail_d;
    logic [LEN_W-1:0]              pat_len_q, pat_len_d;
    logic [LEN_W-1:0]              i_q, i_d;
    logic [LEN_W-1:0]              k_q, k_d;
    logic [LEN_W-1:0]              q_q, q_d;
    logic                          pending_q, pending_d;
    logic                          held_q, held_d;
    logic                          detected_q, detected_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          b;

    // A pending bit is re-evaluated against the fallen-back state before a new one is taken.
    assign b = pending_q ? held_q : data_in;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        fail_d     = fail_q;
        pat_len_d  = pat_len_q;
        i_d        = i_q;
        k_d        = k_q;
        q_d        = q_q;
        pending_d  = pending_q;
        held_d     = held_q;
        detected_d = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    pat_d[IDX_W'(pat_len_q)] = cfg_bit;
                    pat_len_d = pat_len_q + 1'b1;
                    if (cfg_last || (pat_len_q == MAX_L - 1'b1)) begin
                        state_d   = S_BUILD;
                        i_d       = LEN_W'(1);
                        k_d       = '0;
                        fail_d[0] = '0;
                    end
                end
            end

            S_BUILD: begin
                if (i_q >= pat_len_q) begin
                    state_d = S_READY;
                end else begin
                    if (pat_q[IDX_W'(i_q)] == pat_q[IDX_W'(k_q)]) begin
                        fail_d[IDX_W'(i_q)] = k_q + 1'b1;
                        k_d = k_q + 1'b1;
                        i_d = i_q + 1'b1;
                    end else if (k_q != '0) begin
                        k_d = fail_q[IDX_W'(k_q - 1'b1)];
                    end else begin
                        fail_d[IDX_W'(i_q)] = '0;
                        i_d = i_q + 1'b1;
                    end
                    // Leave on the step that fills the last entry, not one cycle later.
                    if (i_d == pat_len_q) state_d = S_READY;
                end
            end

            S_READY: begin
                if (start) begin
                    state_d   = S_RUN;
                    q_d       = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end

            S_RUN: begin
                if (stop) begin
                    state_d   = S_READY;
                    pending_d = 1'b0;
                end else if (pending_q || data_valid) begin
                    if (b == pat_q[IDX_W'(q_q)]) begin
                        pending_d = 1'b0;
                        if (q_q + 1'b1 == pat_len_q) begin
                            detected_d = 1'b1;
                            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                            q_d = overlap ? fail_q[IDX_W'(pat_len_q - 1'b1)] : '0;
                        end else begin
                            q_d = q_q + 1'b1;
                        end
                    end else if (q_q != '0) begin
                        q_d       = fail_q[IDX_W'(q_q - 1'b1)];
                        held_d    = b;
                        pending_d = 1'b1;
                    end else begin
                        pending_d = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            fail_q     <= '0;
            pat_len_q  <= '0;
            i_q        <= '0;
            k_q        <= '0;
            q_q        <= '0;
            pending_q  <= 1'b0;
            held_q     <= 1'b0;
            detected_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            fail_q     <= fail_d;
            pat_len_q  <= pat_len_d;
            i_q        <= i_d;
            k_q        <= k_d;
            q_q        <= q_d;
            pending_q  <= pending_d;
            held_q     <= held_d;
            detected_q <= detected_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign data_ready  = (state_q == S_RUN) && !pending_q;
    assign detected    = detected_q;
    assign match_count = cnt_q;
    assign pat_len     = pat_len_q;
    assign state_o     = state_q;

endmodule
